// File: rtl/data_sramlike_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_sramlike_axi_bridge
// Brief    : Data-side SRAM-like slave port to single-beat AXI read/write
//            master. One transaction in flight; request fields are latched
//            at the address handshake.
// Options  : DATA_BRIDGE_EARLY_WRITE_ACK_EN - report write completion once
//            AW and W have both handshaken, without waiting for B.
// Revision : 1.0 - initial release
// ============================================================================
module data_sramlike_axi_bridge #(
    parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF,
    parameter int          TIMEOUT_W = 0
) (
    input  logic        clk,
    input  logic        rst,
    // SRAM-like side
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AXI read address / data
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address / data / response
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    // No timeout logic exists; any other value is a configuration error.
    generate
        if (TIMEOUT_W != 0) begin : g_timeout_unsupported
            $error("data_sramlike_axi_bridge: TIMEOUT_W must be 0");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_AR  = 3'd1,
        ST_RD_R   = 3'd2,
        ST_WR_REQ = 3'd3,
        ST_WR_B   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] addr_q,    addr_d;
    logic [1:0]  size_q,    size_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
    logic [31:0] rdata_q,   rdata_d;
`ifdef DATA_BRIDGE_EARLY_WRITE_ACK_EN
    logic        early_ok_q, early_ok_d;
`endif

    logic [3:0]  w_req_wstrb;

    // Byte-lane strobes derived from the request size and low address bits.
    always_comb begin
        w_req_wstrb = 4'b1111;
        case (data_size)
            2'd0:    w_req_wstrb = 4'b0001 << data_addr[1:0];
            2'd1:    w_req_wstrb = 4'b0011 << {data_addr[1], 1'b0};
            default: w_req_wstrb = 4'b1111;
        endcase
    end

    // Next-state and handshake outputs; everything defaults to idle values.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
`ifdef DATA_BRIDGE_EARLY_WRITE_ACK_EN
        early_ok_d   = 1'b0;
`endif
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                data_addr_ok = data_req;
                if (data_req) begin
                    addr_d    = data_addr & PHYS_MASK;
                    size_d    = data_size;
                    wdata_d   = data_wdata;
                    wstrb_d   = w_req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = data_wr ? ST_WR_REQ : ST_RD_AR;
                end
            end
            ST_RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_RD_R;
                end
            end
            ST_RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata;
                    state_d = ST_DONE;
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently, in either order.
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_B;
`ifdef DATA_BRIDGE_EARLY_WRITE_ACK_EN
                    early_ok_d = 1'b1;
`endif
                end
            end
            ST_WR_B: begin
                bready = 1'b1;
`ifdef DATA_BRIDGE_EARLY_WRITE_ACK_EN
                // Completion was pulsed on entry, so B returns straight to idle.
                data_data_ok = early_ok_q;
                if (bvalid) begin
                    state_d = ST_IDLE;
                end
`else
                if (bvalid) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                data_data_ok = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched request fields; async reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            size_q     <= 2'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rdata_q    <= 32'd0;
`ifdef DATA_BRIDGE_EARLY_WRITE_ACK_EN
            early_ok_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rdata_q    <= rdata_d;
`ifdef DATA_BRIDGE_EARLY_WRITE_ACK_EN
            early_ok_q <= early_ok_d;
`endif
        end
    end

    // Channel payloads are zero whenever their valid is low.
    assign araddr     = arvalid ? addr_q : 32'd0;
    assign arsize     = arvalid ? {1'b0, size_q} : 3'd0;
    assign awaddr     = awvalid ? addr_q : 32'd0;
    assign awsize     = awvalid ? {1'b0, size_q} : 3'd0;
    assign wdata      = wvalid ? wdata_q : 32'd0;
    assign wstrb      = wvalid ? wstrb_q : 4'd0;
    assign data_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sramlike_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sramlike_axi_bridge
// Brief    : Scoreboard bench for data_sramlike_axi_bridge with a delay-
//            configurable single-beat AXI slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sramlike_axi_bridge;

    logic        clk, rst;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    data_sramlike_axi_bridge dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct { bit wr; logic [31:0] rdata; int lat; int aw_cyc; int w_cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic [2:0] size; } a_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;

    resp_t       exp_resp[$];
    a_t          exp_ar[$];
    a_t          exp_aw[$];
    w_t          exp_w[$];
    logic [31:0] rd_data_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_addr_hs = 0;
    logic [31:0] last_rd = 32'd0;

    // slave delay configuration (cycles of valid before ready / before response)
    int ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // AXI slave model: drives on the falling edge, handshakes land on the rising edge.
    initial begin : slave
        bit ar_hs, aw_hs, w_hs, r_hs, b_hs, aw_got, w_got, r_pend, b_pend;
        int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt, r_lim, b_lim;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rdata = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
        r_pend = 0; b_pend = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        r_lim = 0; b_lim = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
                ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
                r_pend = 0; b_pend = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
                rd_data_q.delete();
                continue;
            end
            if (ar_hs) begin arready = 0; ar_hs = 0; r_pend = 1; r_cnt = 0; r_lim = r_delay; end
            if (aw_hs) begin awready = 0; aw_hs = 0; aw_got = 1; end
            if (w_hs)  begin wready = 0;  w_hs = 0;  w_got = 1;  end
            if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; b_lim = b_delay; aw_got = 0; w_got = 0; end
            if (r_hs) begin rvalid = 0; r_hs = 0; end
            if (b_hs) begin bvalid = 0; b_hs = 0; end
            if (arvalid && !arready) begin
                if (ar_cnt >= ar_delay) begin arready = 1; ar_cnt = 0; end else ar_cnt++;
            end
            if (awvalid && !awready) begin
                if (aw_cnt >= aw_delay) begin awready = 1; aw_cnt = 0; end else aw_cnt++;
            end
            if (wvalid && !wready) begin
                if (w_cnt >= w_delay) begin wready = 1; w_cnt = 0; end else w_cnt++;
            end
            if (r_pend && !rvalid) begin
                if (r_cnt >= r_lim) begin
                    rvalid = 1; r_pend = 0;
                    rdata = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 32'h0;
                end else r_cnt++;
            end
            if (b_pend && !bvalid) begin
                if (b_cnt >= b_lim) begin bvalid = 1; b_pend = 0; end else b_cnt++;
            end
            #1;
            ar_hs = arvalid && arready;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            r_hs  = rvalid && rready;
            b_hs  = bvalid && bready;
        end
    end

    // Monitor / scoreboard: pops expectations whenever the DUT presents an event.
    initial begin : monitor
        bit busy, cur_wr, aw_seen, w_seen;
        int addr_cyc, b_cyc, aw_cnt, w_cnt;
        resp_t r;
        a_t a;
        w_t wx;
        busy = 0; cur_wr = 0; aw_seen = 0; w_seen = 0;
        addr_cyc = 0; b_cyc = -100; aw_cnt = 0; w_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin busy = 0; continue; end
            if (data_addr_ok || data_data_ok)
                check("addr_ok_data_ok_exclusive", {31'd0, data_addr_ok && data_data_ok}, 32'd0);
            if (data_addr_ok) check("addr_ok_while_busy", {31'd0, busy}, 32'd0);
            if (awvalid) aw_cnt++;
            if (wvalid)  w_cnt++;
            if (bready)  check("bready_before_aw_w_done", {30'd0, aw_seen, w_seen}, 32'd3);
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) check("unexpected_ar", 32'd1, 32'd0);
                else begin
                    a = exp_ar.pop_front();
                    check("araddr", araddr, a.addr);
                    check("arsize", {29'd0, arsize}, {29'd0, a.size});
                end
            end
            if (awvalid && awready) begin
                aw_seen = 1;
                if (exp_aw.size() == 0) check("unexpected_aw", 32'd1, 32'd0);
                else begin
                    a = exp_aw.pop_front();
                    check("awaddr", awaddr, a.addr);
                    check("awsize", {29'd0, awsize}, {29'd0, a.size});
                end
            end
            if (wvalid && wready) begin
                w_seen = 1;
                if (exp_w.size() == 0) check("unexpected_w", 32'd1, 32'd0);
                else begin
                    wx = exp_w.pop_front();
                    check("wdata", wdata, wx.data);
                    check("wstrb", {28'd0, wstrb}, {28'd0, wx.strb});
                end
            end
            if (bvalid && bready) begin
                b_cyc = cyc;
`ifdef DATA_BRIDGE_EARLY_WRITE_ACK_EN
                if (cur_wr) busy = 0;
`endif
            end
            if (data_data_ok) begin
                if (exp_resp.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
                else begin
                    r = exp_resp.pop_front();
                    check("completion_kind", {31'd0, cur_wr}, {31'd0, r.wr});
                    if (r.lat >= 0) check("latency", cyc - addr_cyc, r.lat);
                    if (!r.wr) begin
                        check("read_data", data_rdata, r.rdata);
                        last_rd = r.rdata;
                        busy = 0;
                    end else begin
                        check("rdata_hold_on_write", data_rdata, last_rd);
                        check("awvalid_cycles", aw_cnt, r.aw_cyc);
                        check("wvalid_cycles", w_cnt, r.w_cyc);
`ifndef DATA_BRIDGE_EARLY_WRITE_ACK_EN
                        check("data_ok_after_b", cyc - b_cyc, 32'd1);
                        busy = 0;
`endif
                    end
                end
            end
            if (data_req && data_addr_ok) begin
                addr_cyc = cyc; busy = 1; cur_wr = data_wr;
                aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0;
                n_addr_hs++;
            end
        end
    end

    task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
        #1;
        n = 0;
        while (!data_addr_ok && n < 60) begin @(negedge clk); #1; n++; end
        check("addr_ok_timeout", {31'd0, data_addr_ok}, 32'd1);
        @(negedge clk);
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_resp.size() != 0 && n < 300) begin @(negedge clk); n++; end
        check("completion_timeout", exp_resp.size(), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] pa, input logic [1:0] sz,
                           input logic [31:0] rd, input int ard, input int rdl, input int lat);
        ar_delay = ard; r_delay = rdl;
        exp_ar.push_back('{addr: pa, size: {1'b0, sz}});
        rd_data_q.push_back(rd);
        exp_resp.push_back('{wr: 1'b0, rdata: rd, lat: lat, aw_cyc: 0, w_cyc: 0});
        issue(1'b0, sz, a, 32'h0);
        wait_done();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] pa, input logic [1:0] sz,
                            input logic [31:0] wd, input logic [3:0] strb,
                            input int awd, input int wdl, input int bd,
                            input int lat_n, input int lat_e, input int awc, input int wc);
        int lat;
`ifdef DATA_BRIDGE_EARLY_WRITE_ACK_EN
        lat = lat_e;
`else
        lat = lat_n;
`endif
        aw_delay = awd; w_delay = wdl; b_delay = bd;
        exp_aw.push_back('{addr: pa, size: {1'b0, sz}});
        exp_w.push_back('{data: wd, strb: strb});
        exp_resp.push_back('{wr: 1'b1, rdata: 32'h0, lat: lat, aw_cyc: awc, w_cyc: wc});
        issue(1'b1, sz, a, wd);
        wait_done();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, base;
        rst = 1; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_bready", {31'd0, bready}, 32'd0);
        check("rst_data_ok", {31'd0, data_data_ok}, 32'd0);
        check("rst_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wstrb", {28'd0, wstrb}, 32'd0);
        @(negedge clk);
        rst = 0;

        // word read through kseg1, zero-wait
        do_read(32'hBFC0_0004, 32'h1FC0_0004, 2'd2, 32'hDEAD_BEEF, 0, 0, 3);
        // byte write to lane 3
        do_write(32'h8000_0003, 32'h0000_0003, 2'd0, 32'hAB00_0000, 4'b1000, 0, 0, 0, 3, 2, 1, 1);
        // half write to upper half
        do_write(32'hA000_0002, 32'h0000_0002, 2'd1, 32'h1234_0000, 4'b1100, 0, 0, 0, 3, 2, 1, 1);
        // byte read
        do_read(32'h8000_1001, 32'h0000_1001, 2'd0, 32'h0055_0000, 0, 0, 3);
        // awready delayed: AW held 3 cycles, W 1 cycle
        do_write(32'h0000_0010, 32'h0000_0010, 2'd2, 32'hCAFE_F00D, 4'b1111, 2, 0, 0, 5, 4, 3, 1);
        // wready delayed: W held 4 cycles, AW 1 cycle
        do_write(32'hC000_0020, 32'h0000_0020, 2'd1, 32'h0000_BEEF, 4'b0011, 0, 3, 0, 6, 5, 1, 4);
        // bvalid delayed 5 cycles, size 3 treated as word strobes
        do_write(32'h8000_0104, 32'h0000_0104, 2'd3, 32'h7654_3210, 4'b1111, 0, 0, 5, 8, 2, 1, 1);
        // slow read: AR waits 2, R waits 3
        do_read(32'h9000_0008, 32'h1000_0008, 2'd2, 32'h0BAD_F00D, 2, 3, 8);

        // back-to-back reads with data_req held high
        ar_delay = 0; r_delay = 0;
        exp_ar.push_back('{addr: 32'h1FC0_0008, size: 3'd2});
        exp_ar.push_back('{addr: 32'h1FC0_0008, size: 3'd2});
        rd_data_q.push_back(32'h0102_0304);
        rd_data_q.push_back(32'h0506_0708);
        exp_resp.push_back('{wr: 1'b0, rdata: 32'h0102_0304, lat: 3, aw_cyc: 0, w_cyc: 0});
        exp_resp.push_back('{wr: 1'b0, rdata: 32'h0506_0708, lat: 3, aw_cyc: 0, w_cyc: 0});
        base = n_addr_hs;
        @(negedge clk);
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'hBFC0_0008;
        n = 0;
        while (n_addr_hs < base + 2 && n < 60) begin @(negedge clk); #3; n++; end
        check("b2b_two_accepts", n_addr_hs - base, 32'd2);
        @(negedge clk);
        data_req = 0; data_addr = 0; data_size = 0;
        wait_done();

        // async reset while waiting in RD_R
        ar_delay = 0; r_delay = 20;
        exp_ar.push_back('{addr: 32'h1FC0_0100, size: 3'd2});
        rd_data_q.push_back(32'h1111_2222);
        exp_resp.push_back('{wr: 1'b0, rdata: 32'h1111_2222, lat: -1, aw_cyc: 0, w_cyc: 0});
        issue(1'b0, 2'd2, 32'h9FC0_0100, 32'h0);
        n = 0;
        while (!rready && n < 20) begin @(negedge clk); #3; n++; end
        check("reached_rd_r", {31'd0, rready}, 32'd1);
        #1;
        rst = 1;
        #1;
        exp_resp.delete();
        last_rd = 32'd0;
        check("abort_arvalid", {31'd0, arvalid}, 32'd0);
        check("abort_rready", {31'd0, rready}, 32'd0);
        check("abort_data_ok", {31'd0, data_data_ok}, 32'd0);
        check("abort_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        check("abort_data_rdata", data_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        // clean restart after the abort
        do_read(32'h8000_0040, 32'h0000_0040, 2'd2, 32'h5A5A_A5A5, 0, 0, 3);
        do_write(32'h8000_0041, 32'h0000_0041, 2'd0, 32'h0000_CC00, 4'b0010, 0, 0, 0, 3, 2, 1, 1);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
